fp_addsub: RTL and testbench

FP_ADDSUB -- requirements
Module: fp_addsub

---
 rtl/fp_addsub_pkg.sv | 52 +++++
 rtl/fp_lzc.sv | 24 ++
 rtl/fp_addsub.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_fp_addsub.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fp_addsub_pkg.sv
// Shared types, field geometry helpers and special-value constants for fp_addsub.
package fp_addsub_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND
  } state_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic zero;
  } flags_t;

  // guard, round and sticky bits carried below the stored mantissa
  localparam int GRS_W = 3;
  localparam int MAX_W = 64;

  function automatic int word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // hidden one + stored mantissa + guard/round/sticky
  function automatic int ext_w(input int man_w);
    return man_w + 1 + GRS_W;
  endfunction

  function automatic int exp_lsb(input int man_w);
    return man_w;
  endfunction

  function automatic int sign_pos(input int exp_w, input int man_w);
    return exp_w + man_w;
  endfunction

  function automatic logic [MAX_W-1:0] inf_bits(input int exp_w, input int man_w,
                                                input logic sign);
    logic [MAX_W-1:0] r;
    r = ((MAX_W'(1) << exp_w) - MAX_W'(1)) << man_w;
    r = r | (MAX_W'(sign) << (exp_w + man_w));
    return r;
  endfunction

  // canonical quiet NaN: positive, exponent all ones, mantissa MSB set
  function automatic logic [MAX_W-1:0] qnan_bits(input int exp_w, input int man_w);
    return inf_bits(exp_w, man_w, 1'b0) | (MAX_W'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter int WIDTH = 11
) (
  input  logic [WIDTH-1:0]           value,
  output logic [$clog2(WIDTH+1)-1:0] count,
  output logic                       all_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // scanning upward lets the highest set bit win the last assignment
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) begin
        count = CNT_W'(WIDTH - 1 - i);
      end
    end
  end

  assign all_zero = ~|value;

endmodule

// File: rtl/fp_addsub.sv
// Multi-cycle floating-point add/subtract with a fixed 4-cycle latency.
// Build option FP_ADDSUB_ROUND_EN: round-to-nearest-even in ROUND; otherwise truncate.
module fp_addsub
  import fp_addsub_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   sub,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic [EXP_W+MAN_W:0]   sum,
  output logic                   ready,
  output logic                   done,
  output logic [2:0]             flags
);

  // state | meaning
  // IDLE  | result held, new start accepted
  // ALIGN | order operands by magnitude, shift smaller mantissa, catch specials
  // ADD   | signed mantissa add/subtract with carry
  // NORM  | normalise, detect exact zero, underflow and overflow
  // ROUND | round or truncate, register result and flags

  localparam int W     = word_w(EXP_W, MAN_W);
  localparam int F     = ext_w(MAN_W);
  localparam int CNT_W = $clog2(F + 1);
  localparam int SIGN  = sign_pos(EXP_W, MAN_W);
  localparam int ELSB  = exp_lsb(MAN_W);

  localparam logic [MAX_W-1:0] QNAN_FULL = qnan_bits(EXP_W, MAN_W);
  localparam logic [MAX_W-1:0] INF_FULL  = inf_bits(EXP_W, MAN_W, 1'b0);
  localparam logic [W-1:0]     QNAN      = QNAN_FULL[W-1:0];
  localparam logic [W-2:0]     INF_MAG   = INF_FULL[W-2:0];
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;

  state_t state, state_n;

  logic [W-1:0]     a_q, b_q;
  logic [F-1:0]     big_man_q, small_man_q;
  logic [EXP_W-1:0] exp_q;
  logic             sign_q, eff_sub_q;
  logic             spec_hit_q;
  logic [W-1:0]     spec_word_q;
  flags_t           spec_flags_q;
  logic [F:0]       add_q;
  logic [F-1:0]     norm_man_q;
  logic [EXP_W-1:0] norm_exp_q;
  logic             norm_zero_q, norm_ovf_q;
  logic [W-1:0]     sum_q;
  flags_t           flags_q;
  logic             ready_q, done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start && ready_q) state_n = ST_ALIGN;
      ST_ALIGN: state_n = ST_ADD;
      ST_ADD:   state_n = ST_NORM;
      ST_NORM:  state_n = ST_ROUND;
      ST_ROUND: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // ALIGN: operand decode, magnitude ordering and sticky right shift
  logic             sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
  logic [EXP_W-1:0] ea, eb, big_e, small_e, diff;
  logic [MAN_W-1:0] ma, mb;
  logic [F-1:0]     a_mx, b_mx, big_mx, small_mx, small_al;
  logic             spec_hit;
  logic [W-1:0]     spec_word;
  flags_t           spec_flags;

  assign sa    = a_q[SIGN];
  assign sb    = b_q[SIGN];
  assign ea    = a_q[SIGN-1:ELSB];
  assign eb    = b_q[SIGN-1:ELSB];
  assign ma    = a_q[ELSB-1:0];
  assign mb    = b_q[ELSB-1:0];
  assign a_nan = (ea == EXP_ONES) && (ma != '0);
  assign b_nan = (eb == EXP_ONES) && (mb != '0);
  assign a_inf = (ea == EXP_ONES) && (ma == '0);
  assign b_inf = (eb == EXP_ONES) && (mb == '0);
  // exponent zero is a signed zero: no hidden one, mantissa discarded
  assign a_mx  = (ea == '0) ? '0 : {1'b1, ma, {GRS_W{1'b0}}};
  assign b_mx  = (eb == '0) ? '0 : {1'b1, mb, {GRS_W{1'b0}}};

  assign swap     = b_q[W-2:0] > a_q[W-2:0];
  assign big_e    = swap ? eb : ea;
  assign small_e  = swap ? ea : eb;
  assign big_mx   = swap ? b_mx : a_mx;
  assign small_mx = swap ? a_mx : b_mx;
  assign diff     = big_e - small_e;

  always_comb begin
    small_al = '0;
    if (int'(diff) >= F - 1) begin
      small_al = {{(F-1){1'b0}}, |small_mx};
    end else begin
      small_al = (small_mx >> diff)
               | {{(F-1){1'b0}}, |(small_mx & ~({F{1'b1}} << diff))};
    end
  end

  always_comb begin
    spec_hit   = 1'b0;
    spec_word  = '0;
    spec_flags = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      spec_hit           = 1'b1;
      spec_word          = QNAN;
      spec_flags.invalid = 1'b1;
    end else if (a_inf) begin
      spec_hit  = 1'b1;
      spec_word = a_q;
    end else if (b_inf) begin
      spec_hit  = 1'b1;
      spec_word = b_q;
    end
  end

  // ADD: ordering guarantees big >= small, so subtraction never goes negative
  logic [F:0] add_n;
  assign add_n = eff_sub_q ? ({1'b0, big_man_q} - {1'b0, small_man_q})
                           : ({1'b0, big_man_q} + {1'b0, small_man_q});

  // NORM
  logic [CNT_W-1:0] lz;
  logic             lz_zero;
  logic [EXP_W:0]   exp_inc;
  logic [EXP_W+1:0] exp_dec;
  logic [F-1:0]     n_man;
  logic [EXP_W-1:0] n_exp;
  logic             n_zero, n_ovf;

  fp_lzc #(.WIDTH(F)) u_lzc (
    .value    (add_q[F-1:0]),
    .count    (lz),
    .all_zero (lz_zero)
  );

  assign exp_inc = {1'b0, exp_q} + (EXP_W+1)'(1);
  assign exp_dec = {2'b00, exp_q} - (EXP_W+2)'(lz);

  always_comb begin
    n_man  = '0;
    n_exp  = '0;
    n_zero = 1'b0;
    n_ovf  = 1'b0;
    if (add_q[F]) begin
      n_man = add_q[F:1] | {{(F-1){1'b0}}, add_q[0]};
      n_exp = exp_inc[EXP_W-1:0];
      n_ovf = exp_inc >= {1'b0, EXP_ONES};
    end else if (lz_zero) begin
      n_zero = 1'b1;
    end else if (exp_dec[EXP_W+1] || (exp_dec == '0)) begin
      // below the smallest normal: flush to +0
      n_zero = 1'b1;
    end else begin
      n_man = add_q[F-1:0] << lz;
      n_exp = exp_dec[EXP_W-1:0];
    end
  end

  // ROUND
  logic [MAN_W:0]   kept;
  logic [GRS_W-1:0] grs;
  logic             round_up, r_carry, r_ovf;
  logic [MAN_W+1:0] rounded;
  logic [MAN_W-1:0] r_frac;
  logic [EXP_W:0]   r_exp;
  logic [W-1:0]     res_word;
  flags_t           res_flags;

  assign kept = norm_man_q[F-1:GRS_W];
  assign grs  = norm_man_q[GRS_W-1:0];

`ifdef FP_ADDSUB_ROUND_EN
  assign round_up = grs[2] & (grs[1] | grs[0] | kept[0]);
`else
  logic unused_grs;
  assign unused_grs = ^grs;
  assign round_up   = 1'b0;
`endif

  assign rounded = {1'b0, kept} + (MAN_W+2)'(round_up);
  assign r_carry = rounded[MAN_W+1];
  assign r_frac  = r_carry ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
  assign r_exp   = {1'b0, norm_exp_q} + (EXP_W+1)'(r_carry);
  assign r_ovf   = norm_ovf_q || (r_exp >= {1'b0, EXP_ONES});

  always_comb begin
    res_word  = '0;
    res_flags = '0;
    if (spec_hit_q) begin
      res_word  = spec_word_q;
      res_flags = spec_flags_q;
    end else if (norm_zero_q) begin
      res_flags.zero = 1'b1;
    end else if (r_ovf) begin
      res_word           = {sign_q, INF_MAG};
      res_flags.overflow = 1'b1;
    end else begin
      res_word = {sign_q, r_exp[EXP_W-1:0], r_frac};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q          <= '0;
      b_q          <= '0;
      big_man_q    <= '0;
      small_man_q  <= '0;
      exp_q        <= '0;
      sign_q       <= 1'b0;
      eff_sub_q    <= 1'b0;
      spec_hit_q   <= 1'b0;
      spec_word_q  <= '0;
      spec_flags_q <= '0;
      add_q        <= '0;
      norm_man_q   <= '0;
      norm_exp_q   <= '0;
      norm_zero_q  <= 1'b0;
      norm_ovf_q   <= 1'b0;
      sum_q        <= '0;
      flags_q      <= '0;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      ready_q <= (state_n == ST_IDLE);
      done_q  <= (state == ST_ROUND);
      case (state)
        ST_IDLE: begin
          if (start && ready_q) begin
            a_q <= a;
            b_q <= {b[W-1] ^ sub, b[W-2:0]};
          end
        end
        ST_ALIGN: begin
          big_man_q    <= big_mx;
          small_man_q  <= small_al;
          exp_q        <= big_e;
          sign_q       <= swap ? sb : sa;
          eff_sub_q    <= sa ^ sb;
          spec_hit_q   <= spec_hit;
          spec_word_q  <= spec_word;
          spec_flags_q <= spec_flags;
        end
        ST_ADD: begin
          add_q <= add_n;
        end
        ST_NORM: begin
          norm_man_q  <= n_man;
          norm_exp_q  <= n_exp;
          norm_zero_q <= n_zero;
          norm_ovf_q  <= n_ovf;
        end
        ST_ROUND: begin
          sum_q   <= res_word;
          flags_q <= res_flags;
        end
        default: ;
      endcase
    end
  end

  assign sum   = sum_q;
  assign flags = flags_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_fp_addsub.sv
// Directed bfloat16 vector bench for fp_addsub plus busy, re-issue and reset sequences.
module tb_fp_addsub;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        sub;
  logic [15:0] a, b, sum;
  logic        ready, done;
  logic [2:0]  flags;

  int n_checks = 0;
  int n_pass   = 0;

  fp_addsub dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .ready (ready),
    .done  (done),
    .flags (flags)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] exp_sum;
    logic [2:0]  exp_flags;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // drive one request; returns edges from acceptance until done is seen
  task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vsub,
                       output int edges);
    @(negedge clock);
    a = va; b = vb; sub = vsub; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    edges = 0;
    check("ready_low_after_accept", 32'(ready), 32'd0);
    while (!done && edges < 10) begin
      @(negedge clock);
      edges++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int edges;
    int extra_done;

    vecs[0]  = '{16'h3F80, 16'h3F80, 1'b0, 16'h4000, 3'b000};
    vecs[1]  = '{16'h3FC0, 16'h4020, 1'b0, 16'h4080, 3'b000};
    vecs[2]  = '{16'h3F80, 16'h3F80, 1'b1, 16'h0000, 3'b001};
    vecs[3]  = '{16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, 3'b010};
    vecs[4]  = '{16'h7F80, 16'h7F80, 1'b1, 16'h7FC0, 3'b100};
`ifdef FP_ADDSUB_ROUND_EN
    vecs[5]  = '{16'h3F81, 16'h3B80, 1'b0, 16'h3F82, 3'b000};
`else
    vecs[5]  = '{16'h3F81, 16'h3B80, 1'b0, 16'h3F81, 3'b000};
`endif
    vecs[6]  = '{16'h4000, 16'h3F80, 1'b1, 16'h3F80, 3'b000};
    vecs[7]  = '{16'h7F80, 16'h3F80, 1'b0, 16'h7F80, 3'b000};
    vecs[8]  = '{16'hFF80, 16'h4000, 1'b0, 16'hFF80, 3'b000};
    vecs[9]  = '{16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0, 3'b100};
    vecs[10] = '{16'h0000, 16'h3FC0, 1'b0, 16'h3FC0, 3'b000};
    vecs[11] = '{16'h3F80, 16'hBF80, 1'b0, 16'h0000, 3'b001};
    vecs[12] = '{16'hC000, 16'h3F80, 1'b0, 16'hBF80, 3'b000};
    vecs[13] = '{16'h3F80, 16'h3380, 1'b0, 16'h3F80, 3'b000};
    vecs[14] = '{16'h7F00, 16'h7F00, 1'b0, 16'h7F80, 3'b010};

    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;

    // reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("reset%0d_ready", i), 32'(ready), 32'd0);
      check($sformatf("reset%0d_done", i), 32'(done), 32'd0);
      check($sformatf("reset%0d_sum", i), 32'(sum), 32'd0);
      check($sformatf("reset%0d_flags", i), 32'(flags), 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_ready", 32'(ready), 32'd1);
    check("post_reset_done", 32'(done), 32'd0);

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, edges);
      check($sformatf("v%0d_latency", i), 32'(edges), 32'd4);
      check($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].exp_sum));
      check($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].exp_flags));
      check($sformatf("v%0d_ready", i), 32'(ready), 32'd1);
      @(negedge clock);
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      check($sformatf("v%0d_sum_held", i), 32'(sum), 32'(vecs[i].exp_sum));
    end

    // start held with different operands while busy must be ignored
    @(negedge clock);
    a = 16'h3F80; b = 16'h3F80; sub = 1'b0; start = 1'b1;
    @(negedge clock);
    a = 16'h4000; b = 16'h4000;
    edges = 0;
    check("busy_ready_low", 32'(ready), 32'd0);
    while (!done && edges < 10) begin
      if (edges == 2) start = 1'b0;
      @(negedge clock);
      edges++;
    end
    start = 1'b0;
    check("busy_latency", 32'(edges), 32'd4);
    check("busy_sum", 32'(sum), 32'h4000);
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (done) extra_done++;
    end
    check("busy_no_second_done", 32'(extra_done), 32'd0);
    check("busy_sum_stable", 32'(sum), 32'h4000);

    // start held high re-issues every five cycles
    @(negedge clock);
    a = 16'h3F80; b = 16'h3F80; sub = 1'b0; start = 1'b1;
    @(negedge clock);
    edges = 0;
    while (!done && edges < 10) begin
      @(negedge clock);
      edges++;
    end
    check("reissue_first_latency", 32'(edges), 32'd4);
    check("reissue_first_sum", 32'(sum), 32'h4000);
    a = 16'h4000; b = 16'h4000;
    @(negedge clock);
    edges = 1;
    check("reissue_ready_low", 32'(ready), 32'd0);
    while (!done && edges < 12) begin
      @(negedge clock);
      edges++;
    end
    start = 1'b0;
    check("reissue_period", 32'(edges), 32'd5);
    check("reissue_second_sum", 32'(sum), 32'h4080);
    @(negedge clock);
    check("reissue_done_pulse", 32'(done), 32'd0);

    // reset during the second cycle of an operation aborts it
    @(negedge clock);
    a = 16'h3F80; b = 16'h3F80; sub = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_sum", 32'(sum), 32'h0000);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (done) extra_done++;
    end
    check("abort_no_done", 32'(extra_done), 32'd0);
    check("abort_sum_after", 32'(sum), 32'h0000);
    check("abort_ready_after", 32'(ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
